// File: rtl/vic_nested_ctrl.sv
// Nested vectored interrupt controller: fixed-priority edge-triggered sources, preemption,
// tail-chaining on return, and a hardware stack of {return PC, preempted level}.
module vic_nested_ctrl #(
    parameter int          N_IRQ       = 8,
    parameter int          ADDR_W      = 32,
    parameter int          STACK_DEPTH = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
    parameter int          VEC_STRIDE  = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [ADDR_W-1:0]                i_PC,
    input  logic                             i_PC_stall,
    input  logic                             i_reti,
    input  logic [N_IRQ-1:0]                 i_irq,
    input  logic [N_IRQ-1:0]                 i_irq_mask,
    output logic                             o_IRQ,
    output logic [ADDR_W-1:0]                o_VIC_iaddr,
    output logic                             o_VIC_PC_ctrl,
    output logic [$clog2(N_IRQ)-1:0]         o_irq_id,
    output logic [$clog2(STACK_DEPTH+1)-1:0] o_nest_level,
    output logic                             o_err
);
    localparam int ID_W    = $clog2(N_IRQ);
    localparam int LVL_W   = $clog2(N_IRQ + 1);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {IDLE, REDIR} state_t;

    state_t              state_reg;
    logic [N_IRQ-1:0]    irq_prev_reg;
    logic [N_IRQ-1:0]    pend_reg;
    logic                reti_pend_reg;
    logic [DEPTH_W-1:0]  depth_reg;
    logic [ID_W-1:0]     irq_id_reg;
    logic [ADDR_W-1:0]   iaddr_reg;
    logic                pc_ctrl_reg;
    logic                irq_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   pc_stack [STACK_DEPTH];
    logic [LVL_W-1:0]    lvl_stack [STACK_DEPTH];

    logic [N_IRQ-1:0]    rise;
    logic [N_IRQ-1:0]    req;
    logic [N_IRQ-1:0]    clr_mask;
    logic                cand_valid;
    logic [ID_W-1:0]     cand;
    logic [LVL_W-1:0]    cur_lvl;
    logic [LVL_W-1:0]    lvl_top;
    logic [PTR_W-1:0]    top_idx;
    logic [PTR_W-1:0]    push_idx;
    logic                reti_now;
    logic                have_frame;
    logic                do_err;
    logic                do_tail;
    logic                do_pop;
    logic                do_push;

    function automatic logic [ADDR_W-1:0] vec_addr(input logic [ID_W-1:0] id);
        return ADDR_W'(VEC_BASE) + ADDR_W'(id) * ADDR_W'(VEC_STRIDE);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_src
            assign rise[gi] = i_irq[gi] & ~irq_prev_reg[gi];
            assign req[gi]  = pend_reg[gi] & i_irq_mask[gi];
        end
    endgenerate

    // Lowest enabled pending index wins.
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                cand_valid = 1'b1;
                cand       = ID_W'(i);
            end
        end
    end

    assign have_frame = (depth_reg != '0);
    assign cur_lvl    = have_frame ? LVL_W'(irq_id_reg) : LVL_W'(N_IRQ);
    assign top_idx    = depth_reg[PTR_W-1:0] - 1'b1;
    assign push_idx   = depth_reg[PTR_W-1:0];
    assign lvl_top    = lvl_stack[top_idx];

    // A latched return from the REDIR window counts as a return on the first IDLE cycle.
    assign reti_now = (state_reg == IDLE) & (i_reti | reti_pend_reg);
    assign do_err   = reti_now & ~have_frame;
    assign do_tail  = reti_now & have_frame & cand_valid & (LVL_W'(cand) < lvl_top);
    assign do_pop   = reti_now & have_frame & ~do_tail;
    assign do_push  = (state_reg == IDLE) & ~reti_now & cand_valid &
                      (LVL_W'(cand) < cur_lvl) & (depth_reg < DEPTH_W'(STACK_DEPTH));
    assign clr_mask = (do_tail | do_push) ? (N_IRQ'(1) << cand) : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg     <= IDLE;
            irq_prev_reg  <= '0;
            pend_reg      <= '0;
            reti_pend_reg <= 1'b0;
            depth_reg     <= '0;
            irq_id_reg    <= '0;
            iaddr_reg     <= '0;
            pc_ctrl_reg   <= 1'b0;
            irq_reg       <= 1'b0;
            err_reg       <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                pc_stack[i]  <= '0;
                lvl_stack[i] <= '0;
            end
        end else begin
            irq_prev_reg <= i_irq;
            pend_reg     <= (pend_reg | rise) & ~clr_mask;
            err_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (reti_now) begin
                        reti_pend_reg <= 1'b0;
                    end
                    if (do_err) begin
                        err_reg <= 1'b1;
                    end
                    if (do_tail || do_push) begin
                        irq_id_reg  <= cand;
                        iaddr_reg   <= vec_addr(cand);
                        pc_ctrl_reg <= 1'b1;
                        state_reg   <= REDIR;
                    end
                    if (do_push) begin
                        pc_stack[push_idx]  <= i_PC;
                        lvl_stack[push_idx] <= cur_lvl;
                        depth_reg           <= depth_reg + 1'b1;
                        irq_reg             <= 1'b1;
                    end
                    if (do_pop) begin
                        irq_id_reg  <= (lvl_top == LVL_W'(N_IRQ)) ? '0 : ID_W'(lvl_top);
                        iaddr_reg   <= pc_stack[top_idx];
                        pc_ctrl_reg <= 1'b1;
                        state_reg   <= REDIR;
                        depth_reg   <= depth_reg - 1'b1;
                        irq_reg     <= (depth_reg != DEPTH_W'(1));
                    end
                end
                REDIR: begin
                    if (i_reti) begin
                        reti_pend_reg <= 1'b1;
                    end
                    if (!i_PC_stall) begin
                        pc_ctrl_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_IRQ         = irq_reg;
    assign o_VIC_iaddr   = iaddr_reg;
    assign o_VIC_PC_ctrl = pc_ctrl_reg;
    assign o_irq_id      = irq_id_reg;
    assign o_nest_level  = depth_reg;
    assign o_err         = err_reg;

endmodule

// File: tb/tb_vic_nested_ctrl.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// queue-based model of the interrupt controller's rules.
module tb_vic_nested_ctrl;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;
    logic        reti = 1'b0;
    logic [7:0]  irq = '0;
    logic [7:0]  mask = '0;
    logic        o_irq_act;
    logic [31:0] o_iaddr;
    logic        o_ctrl;
    logic [2:0]  o_id;
    logic [2:0]  o_nest;
    logic        o_err;

    int vectors = 0;
    int miscompares = 0;

    vic_nested_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_PC         (pc),
        .i_PC_stall   (stall),
        .i_reti       (reti),
        .i_irq        (irq),
        .i_irq_mask   (mask),
        .o_IRQ        (o_irq_act),
        .o_VIC_iaddr  (o_iaddr),
        .o_VIC_PC_ctrl(o_ctrl),
        .o_irq_id     (o_id),
        .o_nest_level (o_nest),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  lvl;
    } frame_t;

    frame_t      stk[$];
    bit [7:0]    m_pend;
    bit [7:0]    m_prev;
    bit          m_redir;
    bit          m_reti_pend;
    int          m_id;
    logic [31:0] m_iaddr;
    bit          m_ctrl;
    bit          m_err;

    task automatic model_reset();
        stk.delete();
        m_pend = '0; m_prev = '0; m_redir = 0; m_reti_pend = 0;
        m_id = 0; m_iaddr = '0; m_ctrl = 0; m_err = 0;
    endtask

    // Applies one clock edge of the controller's rules to the model using current inputs.
    task automatic model_edge();
        bit [7:0] rises;
        bit [7:0] clr;
        bit       found;
        int       c;
        int       cur;
        frame_t   f;
        rises = irq & ~m_prev;
        clr   = '0;
        found = 0;
        c     = N;
        for (int i = 0; i < N; i++)
            if (!found && m_pend[i] && mask[i]) begin found = 1; c = i; end
        m_err = 0;
        if (m_redir) begin
            if (reti) m_reti_pend = 1;
            if (!stall) begin m_ctrl = 0; m_redir = 0; end
        end else if (reti || m_reti_pend) begin
            m_reti_pend = 0;
            if (stk.size() == 0) begin
                m_err = 1;
            end else if (found && c < int'(stk[$].lvl)) begin
                m_id = c; clr[c] = 1; m_iaddr = 32'h100 + c * 4; m_ctrl = 1; m_redir = 1;
            end else begin
                f = stk.pop_back();
                m_id = (int'(f.lvl) == N) ? 0 : int'(f.lvl);
                m_iaddr = f.pc; m_ctrl = 1; m_redir = 1;
            end
        end else begin
            cur = (stk.size() > 0) ? m_id : N;
            if (found && c < cur && stk.size() < DEPTH) begin
                f.pc = pc; f.lvl = 4'(cur);
                stk.push_back(f);
                m_id = c; clr[c] = 1; m_iaddr = 32'h100 + c * 4; m_ctrl = 1; m_redir = 1;
            end
        end
        m_pend = (m_pend | rises) & ~clr;
        m_prev = irq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("iaddr", o_iaddr, m_iaddr);
        check("pc_ctrl", 32'(o_ctrl), 32'(m_ctrl));
        check("irq_active", 32'(o_irq_act), 32'(stk.size() != 0));
        check("irq_id", 32'(o_id), 32'(m_id));
        check("nest_level", 32'(o_nest), 32'(stk.size()));
        check("err", 32'(o_err), 32'(m_err));
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v; tick(); irq = '0; tick();
    endtask

    task automatic do_reti();
        reti = 1'b1; tick(); reti = 1'b0; tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_iaddr", o_iaddr, 32'h0);
        check("reset_ctrl", 32'(o_ctrl), 32'h0);
        check("reset_nest", 32'(o_nest), 32'h0);
        compare_all();
        rst_n = 1'b1;
        mask  = 8'hFF;
        pc    = 32'h40;
        tick();

        // T1 single interrupt and return
        pulse_irq(8'h08);
        check("T1_vec", o_iaddr, 32'h10C);
        check("T1_ctrl", 32'(o_ctrl), 32'h1);
        check("T1_nest", 32'(o_nest), 32'h1);
        check("T1_irq", 32'(o_irq_act), 32'h1);
        tick();
        check("T1_ctrl_drop", 32'(o_ctrl), 32'h0);
        reti = 1'b1; tick(); reti = 1'b0;
        check("T1_ret_pc", o_iaddr, 32'h40);
        check("T1_ret_nest", 32'(o_nest), 32'h0);
        check("T1_ret_irq", 32'(o_irq_act), 32'h0);
        tick();

        // T2 preemption
        pulse_irq(8'h08); tick();
        pc = 32'h200;
        pulse_irq(8'h02);
        check("T2_vec", o_iaddr, 32'h104);
        check("T2_nest", 32'(o_nest), 32'h2);
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        check("T2_ret_pc", o_iaddr, 32'h200);
        check("T2_ret_id", 32'(o_id), 32'h3);
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        check("T2_ret2_pc", o_iaddr, 32'h40);
        tick();

        // T3 no preemption, then tail-chain
        pc = 32'h40;
        pulse_irq(8'h02); tick();
        pc = 32'h300;
        pulse_irq(8'h20);
        check("T3_no_redir", 32'(o_ctrl), 32'h0);
        reti = 1'b1; tick(); reti = 1'b0;
        check("T3_tail_vec", o_iaddr, 32'h114);
        check("T3_tail_nest", 32'(o_nest), 32'h1);
        check("T3_tail_id", 32'(o_id), 32'h5);
        tick();
        reti = 1'b1; tick(); reti = 1'b0;
        check("T3_ret_pc", o_iaddr, 32'h40);
        tick();

        // T4 stall hold, then overflow
        stall = 1'b1;
        pulse_irq(8'h08);
        check("T4_ctrl_on", 32'(o_ctrl), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("T4_ctrl_held", 32'(o_ctrl), 32'h1);
        end
        stall = 1'b0; tick();
        check("T4_ctrl_drop", 32'(o_ctrl), 32'h0);
        do_reti();
        for (int i = 7; i >= 4; i--) begin
            pc = 32'h1000 + i * 16;
            pulse_irq(8'(1 << i)); tick();
        end
        check("T4_full", 32'(o_nest), 32'h4);
        pulse_irq(8'h01); tick();
        check("T4_overflow_hold", 32'(o_ctrl), 32'h0);
        check("T4_overflow_nest", 32'(o_nest), 32'h4);
        reti = 1'b1; tick(); reti = 1'b0;
        check("T4_released_id", 32'(o_id), 32'h0);
        tick();
        repeat (4) do_reti();
        check("T4_unwound", 32'(o_nest), 32'h0);

        // T5 stray return, then reset inside REDIR
        reti = 1'b1; tick(); reti = 1'b0;
        check("T5_err", 32'(o_err), 32'h1);
        check("T5_no_redir", 32'(o_ctrl), 32'h0);
        tick();
        check("T5_err_pulse", 32'(o_err), 32'h0);
        stall = 1'b1;
        pulse_irq(8'h10);
        rst_n = 1'b0;
        #1;
        check("T5_rst_ctrl", 32'(o_ctrl), 32'h0);
        check("T5_rst_iaddr", o_iaddr, 32'h0);
        check("T5_rst_nest", 32'(o_nest), 32'h0);
        check("T5_rst_irq", 32'(o_irq_act), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        model_reset();
        tick();

        // T6 masked source stays pending
        mask = 8'hFB;
        pulse_irq(8'h04); tick(2);
        check("T6_masked", 32'(o_ctrl), 32'h0);
        mask = 8'hFF; tick();
        check("T6_unmask_vec", o_iaddr, 32'h108);
        check("T6_unmask_ctrl", 32'(o_ctrl), 32'h1);
        tick();
        do_reti();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            irq   = 8'($urandom & $urandom & $urandom);
            stall = ($urandom_range(0, 3) == 0);
            reti  = ($urandom_range(0, 9) == 0);
            pc    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 49) == 0) mask = 8'($urandom | $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
